detect_event_logger: RTL and testbench

DETECT_EVENT_LOGGER -- requirements
Module: detect_event_logger

---
 rtl/det_log_pkg.sv | 22 ++
 rtl/det_fifo.sv | 65 ++++++
 rtl/detect_event_logger.sv | 87 ++++++++
 tb/tb_detect_event_logger.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/det_log_pkg.sv
// Shared defaults, types and helpers for the detection event logger.
// Imported by the logger top and its buffer.
package det_log_pkg;

  localparam int unsigned TS_W_DEF  = 16;
  localparam int unsigned DEPTH_DEF = 4;
  localparam int unsigned CNT_W_DEF = 8;

  typedef logic [TS_W_DEF-1:0]  ts_t;
  typedef logic [CNT_W_DEF-1:0] cnt_t;

  // Width-generic saturating increment: holds at 2**w-1.
  function automatic logic [63:0] sat_inc(
    input logic [63:0] v,
    input int unsigned w
  );
    logic [63:0] max_v;
    max_v = (w >= 64) ? '1 : ((64'd1 << w) - 64'd1);
    return (v == max_v) ? v : v + 64'd1;
  endfunction

endpackage

// File: rtl/det_fifo.sv
// First-word-fall-through event buffer; pointers wrap modulo DEPTH,
// full/empty come from an occupancy count one bit wider than the pointers.
module det_fifo
  import det_log_pkg::*;
#(
  parameter int unsigned W     = TS_W_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF
) (
  input  logic         clk,
  input  logic         rstn,
  input  logic         clr,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [AW:0]   r_cnt;

  logic w_wr;
  logic w_rd;

  assign full  = (r_cnt == FULL_CNT);
  assign empty = (r_cnt == '0);
  assign dout  = r_mem[r_rptr];

  // A write into a full buffer is legal only alongside a read.
  assign w_rd = pop & ~empty;
  assign w_wr = push & (~full | w_rd);

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wptr] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn || clr) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_wr) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_rd) begin
        r_rptr <= r_rptr + AW'(1);
      end
      unique case ({w_wr, w_rd})
        2'b10:   r_cnt <= r_cnt + (AW+1)'(1);
        2'b01:   r_cnt <= r_cnt - (AW+1)'(1);
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/detect_event_logger.sv
// Timestamps detector pulses into a FIFO and keeps saturating
// accepted/dropped event statistics.
module detect_event_logger
  import det_log_pkg::*;
#(
  parameter int unsigned TS_W  = TS_W_DEF,
  parameter int unsigned DEPTH = DEPTH_DEF,
  parameter int unsigned CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             clr,
  input  logic             det_in,
  output logic             evt_valid,
  input  logic             evt_ready,
  output logic [TS_W-1:0]  evt_ts,
  output logic [CNT_W-1:0] evt_count,
  output logic [CNT_W-1:0] drop_count,
  output logic             full
);

  logic [TS_W-1:0]  r_ts;
  logic [CNT_W-1:0] r_evt_cnt;
  logic [CNT_W-1:0] r_drop_cnt;

  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_drop;
  logic [TS_W-1:0]  w_dout;
  logic [CNT_W-1:0] w_evt_nxt;
  logic [CNT_W-1:0] w_drop_nxt;

  // clr dominates: nothing moves through the buffer in a clear cycle.
  assign w_pop  = ~w_empty & evt_ready & ~clr;
  assign w_push = det_in & (~w_full | w_pop) & ~clr;
  assign w_drop = det_in & w_full & ~w_pop & ~clr;

  assign w_evt_nxt  = CNT_W'(sat_inc(64'(r_evt_cnt), CNT_W));
  assign w_drop_nxt = CNT_W'(sat_inc(64'(r_drop_cnt), CNT_W));

  det_fifo #(
    .W     (TS_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .clr   (clr),
    .push  (w_push),
    .pop   (w_pop),
    .din   (r_ts),
    .dout  (w_dout),
    .full  (w_full),
    .empty (w_empty)
  );

  always_ff @(posedge clk) begin
    if (!rstn || clr) begin
      r_ts <= '0;
    end else begin
      r_ts <= r_ts + TS_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn || clr) begin
      r_evt_cnt  <= '0;
      r_drop_cnt <= '0;
    end else begin
      if (w_push) begin
        r_evt_cnt <= w_evt_nxt;
      end
      if (w_drop) begin
        r_drop_cnt <= w_drop_nxt;
      end
    end
  end

  // Stale memory is masked so the stamp reads 0 whenever nothing is held.
  assign evt_valid  = ~w_empty;
  assign evt_ts     = w_empty ? '0 : w_dout;
  assign evt_count  = r_evt_cnt;
  assign drop_count = r_drop_cnt;
  assign full       = w_full;

endmodule

// File: tb/tb_detect_event_logger.sv
// Bench for detect_event_logger: queue-based reference model plus
// directed scenarios, on a 16-bit and a 4-bit timestamp instance.
module tb_detect_event_logger;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  logic clr = 1'b0;
  logic det_in = 1'b0;
  logic evt_ready = 1'b0;

  logic        evt_valid;
  logic        full;
  logic [15:0] evt_ts;
  logic [7:0]  evt_count;
  logic [7:0]  drop_count;

  logic        u4_valid;
  logic        u4_full;
  logic [3:0]  u4_ts;
  logic [7:0]  u4_ec;
  logic [7:0]  u4_dc;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  int m_q[$];
  int m_ts = 0;
  int m_ec = 0;
  int m_dc = 0;
  bit m_rst = 1'b0;

  int exp38[3] = '{12, 13, 20};
  int dets;

  always #5 clk = ~clk;

  detect_event_logger u_dut (
    .clk        (clk),
    .rstn       (rstn),
    .clr        (clr),
    .det_in     (det_in),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_ts     (evt_ts),
    .evt_count  (evt_count),
    .drop_count (drop_count),
    .full       (full)
  );

  detect_event_logger #(
    .TS_W  (4),
    .DEPTH (4),
    .CNT_W (8)
  ) u_dut4 (
    .clk        (clk),
    .rstn       (rstn),
    .clr        (clr),
    .det_in     (det_in),
    .evt_valid  (u4_valid),
    .evt_ready  (evt_ready),
    .evt_ts     (u4_ts),
    .evt_count  (u4_ec),
    .drop_count (u4_dc),
    .full       (u4_full)
  );

  task automatic cmp(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp,
               $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ts(input int n);
    int k;
    k = 0;
    while (m_ts != n && k < 200) begin
      tick();
      k++;
    end
    if (m_ts != n) begin
      n_vec++;
      n_bad++;
      $display("FAIL wait_ts: ts %0d never reached (at %0d)", n, m_ts);
    end
  endtask

  // Reference model: the buffer is a plain queue of integer stamps.
  always @(posedge clk) begin
    bit p;
    bit acc;
    if (!rstn || clr) begin
      m_q.delete();
      m_ts = 0;
      m_ec = 0;
      m_dc = 0;
      m_rst = !rstn;
    end else begin
      m_rst = 1'b0;
      p = (m_q.size() > 0) && evt_ready;
      acc = det_in && ((m_q.size() < 4) || p);
      if (p) begin
        void'(m_q.pop_front());
      end
      if (acc) begin
        m_q.push_back(m_ts);
        if (m_ec < 255) m_ec++;
      end else if (det_in) begin
        if (m_dc < 255) m_dc++;
      end
      m_ts++;
    end
  end

  always @(negedge clk) begin
    logic [31:0] hd;
    logic [31:0] mv;
    if (chk_en) begin
      mv = 32'(m_q.size() != 0);
      hd = (m_q.size() != 0) ? m_q[0] : 0;
      cmp("valid", 32'(evt_valid), mv);
      cmp("valid4", 32'(u4_valid), mv);
      cmp("full", 32'(full), 32'(m_q.size() == 4));
      cmp("full4", 32'(u4_full), 32'(m_q.size() == 4));
      cmp("evt_count", 32'(evt_count), m_ec);
      cmp("evt_count4", 32'(u4_ec), m_ec);
      cmp("drop_count", 32'(drop_count), m_dc);
      cmp("drop_count4", 32'(u4_dc), m_dc);
      if (mv[0]) begin
        cmp("evt_ts", 32'(evt_ts), hd & 32'hffff);
        cmp("evt_ts4", 32'(u4_ts), hd & 32'hf);
      end else if (m_rst) begin
        cmp("rst_ts", 32'(evt_ts), 0);
        cmp("rst_ts4", 32'(u4_ts), 0);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) tick();
    chk_en = 1'b1;
    @(negedge clk);
    cmp("rst_valid_lit", 32'(evt_valid), 0);
    cmp("rst_full_lit", 32'(full), 0);
    cmp("rst_evt_lit", 32'(evt_count), 0);
    cmp("rst_drop_lit", 32'(drop_count), 0);
    cmp("rst_ts_lit", 32'(evt_ts), 0);
    rstn = 1'b1;

    evt_ready = 1'b1;
    wait_ts(5);
    det_in = 1'b1;
    tick();
    det_in = 1'b0;
    @(negedge clk);
    cmp("single_valid", 32'(evt_valid), 1);
    cmp("single_ts", 32'(evt_ts), 5);
    cmp("single_cnt", 32'(evt_count), 1);
    tick();
    @(negedge clk);
    cmp("single_gone", 32'(evt_valid), 0);

    clr = 1'b1;
    tick();
    clr = 1'b0;
    evt_ready = 1'b0;
    wait_ts(10);
    det_in = 1'b1;
    repeat (6) tick();
    det_in = 1'b0;
    @(negedge clk);
    cmp("ovf_full", 32'(full), 1);
    cmp("ovf_head", 32'(evt_ts), 10);
    cmp("ovf_drop", 32'(drop_count), 2);
    cmp("ovf_evt", 32'(evt_count), 4);

    wait_ts(20);
    det_in = 1'b1;
    evt_ready = 1'b1;
    tick();
    det_in = 1'b0;
    @(negedge clk);
    cmp("fullpop_head", 32'(evt_ts), 11);
    cmp("fullpop_full", 32'(full), 1);
    cmp("fullpop_drop", 32'(drop_count), 2);
    cmp("fullpop_evt", 32'(evt_count), 5);
    for (int i = 0; i < 3; i++) begin
      tick();
      @(negedge clk);
      cmp("drain_head", 32'(evt_ts), exp38[i]);
    end
    tick();
    @(negedge clk);
    cmp("drain_empty", 32'(evt_valid), 0);

    evt_ready = 1'b0;
    clr = 1'b1;
    tick();
    clr = 1'b0;
    wait_ts(15);
    det_in = 1'b1;
    repeat (2) tick();
    det_in = 1'b0;
    @(negedge clk);
    cmp("wrap4_first", 32'(u4_ts), 15);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    @(negedge clk);
    cmp("wrap4_second", 32'(u4_ts), 0);
    cmp("wrap16_second", 32'(evt_ts), 16);

    clr = 1'b1;
    tick();
    clr = 1'b0;
    evt_ready = 1'b1;
    det_in = 1'b1;
    repeat (300) tick();
    det_in = 1'b0;
    @(negedge clk);
    cmp("sat_evt", 32'(evt_count), 255);
    cmp("sat_evt4", 32'(u4_ec), 255);
    cmp("sat_drop", 32'(drop_count), 0);

    clr = 1'b1;
    tick();
    clr = 1'b0;
    evt_ready = 1'b0;
    det_in = 1'b1;
    repeat (3) tick();
    clr = 1'b1;
    evt_ready = 1'b1;
    tick();
    clr = 1'b0;
    evt_ready = 1'b0;
    @(negedge clk);
    cmp("clr_valid", 32'(evt_valid), 0);
    cmp("clr_evt", 32'(evt_count), 0);
    cmp("clr_drop", 32'(drop_count), 0);
    tick();
    det_in = 1'b0;
    @(negedge clk);
    cmp("clr_ts0", 32'(evt_ts), 0);
    cmp("clr_evt1", 32'(evt_count), 1);

    det_in = 1'b1;
    repeat (3) tick();
    rstn = 1'b0;
    evt_ready = 1'b1;
    tick();
    rstn = 1'b1;
    evt_ready = 1'b0;
    @(negedge clk);
    cmp("rst2_valid", 32'(evt_valid), 0);
    cmp("rst2_evt", 32'(evt_count), 0);
    cmp("rst2_drop", 32'(drop_count), 0);
    cmp("rst2_ts", 32'(evt_ts), 0);
    tick();
    det_in = 1'b0;
    @(negedge clk);
    cmp("rst2_ts0", 32'(evt_ts), 0);
    cmp("rst2_evt1", 32'(evt_count), 1);

    for (int w = 0; w < 5; w++) begin
      clr = 1'b1;
      tick();
      clr = 1'b0;
      dets = 0;
      for (int c = 0; c < 200; c++) begin
        det_in = 1'($urandom_range(0, 1));
        evt_ready = ($urandom_range(0, 4) < 2);
        dets += int'(det_in);
        tick();
      end
      det_in = 1'b0;
      evt_ready = 1'b0;
      @(negedge clk);
      cmp("acc_plus_drop", 32'(evt_count) + 32'(drop_count), dets);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
